// File: rtl/imem_loader.sv
// Boot loader: takes a framed byte stream (length, little-endian words, XOR checksum),
// writes the words to instruction memory from address 0, and releases CPU reset once verified.
module imem_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic                  byte_valid_in,
  input  logic [7:0]            byte_in,
  output logic                  byte_ready_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_we_out,
  output logic                  cpu_rst_n_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} state_t;

  state_t      state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_lo;
  logic [7:0]  csum;

  logic        take;
  logic [15:0] len_full;
  logic [15:0] idx_nxt;

  assign take     = byte_valid_in & byte_ready_out;
  assign len_full = {byte_in, len[7:0]};
  assign idx_nxt  = word_idx + 16'd1;

  // Outputs are registered, so each transition also loads the outputs of the state it enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      len            <= '0;
      word_idx       <= '0;
      byte_idx       <= '0;
      word_lo        <= '0;
      csum           <= '0;
      byte_ready_out <= 1'b0;
      mem_addr_out   <= '0;
      mem_data_out   <= '0;
      mem_we_out     <= 1'b0;
      cpu_rst_n_out  <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      mem_we_out <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start_in) begin
            state          <= LEN0;
            word_idx       <= '0;
            byte_idx       <= '0;
            csum           <= '0;
            byte_ready_out <= 1'b1;
            busy_out       <= 1'b1;
            done_out       <= 1'b0;
            err_out        <= 1'b0;
            cpu_rst_n_out  <= 1'b0;
          end
        end
        LEN0: begin
          if (take) begin
            len[7:0] <= byte_in;
            state    <= LEN1;
          end
        end
        LEN1: begin
          if (take) begin
            len[15:8] <= byte_in;
            if (len_full == 16'd0 || len_full > 16'(MAX_WORDS)) begin
              state          <= ERR;
              byte_ready_out <= 1'b0;
              busy_out       <= 1'b0;
              err_out        <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (take) begin
            csum     <= csum ^ byte_in;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // Fourth byte goes straight to the write port; no need to stage it.
              state          <= WRITE;
              byte_ready_out <= 1'b0;
              mem_we_out     <= 1'b1;
              mem_addr_out   <= ADDR_WIDTH'({word_idx, 2'b00});
              mem_data_out   <= {byte_in, word_lo};
            end else begin
              word_lo[8*byte_idx +: 8] <= byte_in;
            end
          end
        end
        WRITE: begin
          word_idx       <= idx_nxt;
          byte_ready_out <= 1'b1;
          state          <= (idx_nxt == len) ? CSUM : DATA;
        end
        CSUM: begin
          if (take) begin
            byte_ready_out <= 1'b0;
            busy_out       <= 1'b0;
            if (byte_in == csum) begin
              state         <= DONE;
              done_out      <= 1'b1;
              cpu_rst_n_out <= 1'b1;
            end else begin
              state   <= ERR;
              err_out <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
